// File: rtl/serial_subtractor_8bit_if.sv
// Request/response handshake bundle for the bit-serial subtractor.
// master: requester (start/X/Y/Bin/out_ready); slave: the subtractor.
// Optional OVF signal exists only when SUB_OVF_EN is defined.
interface serial_subtractor_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Bin;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             out_valid;
    logic             out_ready;
`ifdef SUB_OVF_EN
    logic             OVF;
`endif

    modport master (
        output start,
        output X,
        output Y,
        output Bin,
        output out_ready,
        input  in_ready,
        input  D,
        input  Bout,
`ifdef SUB_OVF_EN
        input  OVF,
`endif
        input  out_valid
    );

    modport slave (
        input  start,
        input  X,
        input  Y,
        input  Bin,
        input  out_ready,
        output in_ready,
        output D,
        output Bout,
`ifdef SUB_OVF_EN
        output OVF,
`endif
        output out_valid
    );
endinterface

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: D = X - Y - Bin, one bit per clock, WIDTH cycles.
// Ports: clk, rst_n (async active-low), bus (slave modport of
// serial_subtractor_8bit_if: start/in_ready request, D/Bout/out_valid/
// out_ready response). Define SUB_OVF_EN to add the signed OVF flag.
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_subtractor_8bit_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xsr_q, xsr_d;
    logic [WIDTH-1:0] ysr_q, ysr_d;
    logic [WIDTH-1:0] rsr_q, rsr_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bout_q, bout_d;
    logic             vld_q, vld_d;
`ifdef SUB_OVF_EN
    logic             xs_q, xs_d;
    logic             ys_q, ys_d;
    logic             ovf_q, ovf_d;
`endif

    logic             bx, by, bb;
    logic             dbit;
    logic             bnext;
    logic [WIDTH-1:0] rshift;

    // Single full-subtractor cell on the LSBs of the operand shifters.
    always_comb begin
        bx     = xsr_q[0];
        by     = ysr_q[0];
        bb     = brw_q;
        dbit   = bx ^ by ^ bb;
        bnext  = (~bx & by) | (~(bx ^ by) & bb);
        rshift = {dbit, rsr_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        xsr_d   = xsr_q;
        ysr_d   = ysr_q;
        rsr_d   = rsr_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        bout_d  = bout_q;
        vld_d   = vld_q;
`ifdef SUB_OVF_EN
        xs_d    = xs_q;
        ys_d    = ys_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    xsr_d   = bus.X;
                    ysr_d   = bus.Y;
                    brw_d   = bus.Bin;
                    rsr_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SUB_OVF_EN
                    xs_d    = bus.X[WIDTH-1];
                    ys_d    = bus.Y[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                xsr_d = xsr_q >> 1;
                ysr_d = ysr_q >> 1;
                brw_d = bnext;
                rsr_d = rshift;
                cnt_d = cnt_q + 1'b1;
                // Last bit: publish the full word at once so partial
                // results never reach D.
                if (cnt_q == LAST) begin
                    res_d   = rshift;
                    bout_d  = bnext;
                    vld_d   = 1'b1;
                    state_d = DONE;
`ifdef SUB_OVF_EN
                    ovf_d   = (xs_q != ys_q) && (dbit != xs_q);
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xsr_q   <= '0;
            ysr_q   <= '0;
            rsr_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            bout_q  <= 1'b0;
            vld_q   <= 1'b0;
`ifdef SUB_OVF_EN
            xs_q    <= 1'b0;
            ys_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            xsr_q   <= xsr_d;
            ysr_q   <= ysr_d;
            rsr_q   <= rsr_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            bout_q  <= bout_d;
            vld_q   <= vld_d;
`ifdef SUB_OVF_EN
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.D         = res_q;
    assign bus.Bout      = bout_q;
    assign bus.out_valid = vld_q;
`ifdef SUB_OVF_EN
    assign bus.OVF       = ovf_q;
`endif
endmodule

// File: doc/serial_subtractor_8bit.md
# serial_subtractor_8bit

Bit-serial two's-complement subtractor computing D = X − Y − Bin, one bit per clock, through a single full-subtractor cell and a borrow flop. It is the inverse-operation companion to the team's combinational ripple adder, for area-constrained datapaths that can tolerate WIDTH-cycle latency. Operands enter on a valid/ready request handshake. The result is held on a valid/ready response handshake until consumed.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request valid; operands are accepted when start && in_ready
- in_ready  output  1  high only in IDLE
- X  input  WIDTH  minuend, sampled on accept
- Y  input  WIDTH  subtrahend, sampled on accept
- Bin  input  1  borrow-in, sampled on accept
- D  output  WIDTH  difference; stable while out_valid
- Bout  output  1  borrow-out (1 when unsigned X < Y + Bin)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- OVF  output  1  signed overflow (present only with SUB_OVF_EN)

## Operation
- States: IDLE, SHIFT, DONE. The state is encoded in registers.
- IDLE:
  - in_ready = 1.
  - On start, latch X, Y into shift registers, borrow ← Bin, bit counter ← 0, go to SHIFT.
  - start while not IDLE is ignored, and the operands are not sampled.
- SHIFT, each cycle:
  - Take x = xsr[0], y = ysr[0], b = borrow.
  - d = x ^ y ^ b.
  - borrow ← (~x & y) | (~(x ^ y) & b).
  - d is shifted into the MSB of the result shift register.
  - xsr and ysr shift right by one.
  - Counter increments.
  - When counter = WIDTH−1, the transfer completes: D ← final result register, Bout ← final borrow, out_valid ← 1, go to DONE.
- DONE:
  - D, Bout, OVF and out_valid are held unchanged while out_ready = 0.
  - On out_ready, out_valid ← 0 and go to IDLE. A new request cannot be accepted in the same cycle.
- D and Bout change only on entry to DONE. They are never updated during SHIFT, so partial results are invisible.
- Arithmetic is modulo 2^WIDTH. Bout is the unsigned borrow.
- Reset values: state IDLE, D = 0, Bout = 0, out_valid = 0, OVF = 0, in_ready = 1, internal registers 0.
- Reset asserted mid-SHIFT or in DONE aborts the operation. Outputs return to their reset values immediately (asynchronously). The pending result is discarded.

## Timing
- Accept at clock edge T0.
- SHIFT occupies the edges T1..TWIDTH.
- out_valid rises at edge TWIDTH: WIDTH cycles after accept (8 for the default).
- Minimum request-to-request interval is WIDTH + 2 cycles:
  - WIDTH shift cycles;
  - ≥1 DONE cycle;
  - 1 IDLE cycle.
- in_ready is decoded combinationally from the state register, with no combinational path from start.
- out_valid and D are registered outputs.
- out_ready held high continuously results in exactly one DONE cycle per result.

## Configuration
- SUB_OVF_EN defined:
  - The OVF port exists.
  - On entry to DONE, OVF ← (X[WIDTH−1] ≠ Y[WIDTH−1]) && (D[WIDTH−1] ≠ X[WIDTH−1]). Sign bits are those of the latched operands and final result; Bin is included in D.
  - OVF has the same hold and clear behaviour as Bout.
- SUB_OVF_EN undefined:
  - No OVF port and no overflow logic.
  - All other behaviour and timing are identical.

## Test plan
- X=0x05, Y=0x03, Bin=0, accept at T0 → out_valid at T8, D=0x02, Bout=0, OVF=0.
- X=0x00, Y=0x01, Bin=0 → D=0xFF, Bout=1, OVF=0.
- X=0x80, Y=0x01, Bin=0 → D=0x7F, Bout=0, OVF=1 (with SUB_OVF_EN).
- X=0x10, Y=0x0F, Bin=1 → D=0x00, Bout=0.
- Backpressure:
  - Setup: result X=0x20, Y=0x10 reaches DONE; hold out_ready=0 for 5 cycles while pulsing start with different operands.
  - Response: D stays 0x10 and out_valid stays 1, in_ready stays 0, and the new operands are ignored.
  - Then out_ready=1 for one cycle → IDLE, in_ready=1.
- Reset mid-operation:
  - Stimulus: accept X=0xAA, Y=0x55, then assert rst_n=0 after 3 SHIFT cycles.
  - Response: out_valid=0, D=0x00, Bout=0 immediately, and in_ready=1.
  - Recovery: a following request X=0x03, Y=0x01 yields D=0x02 after 8 cycles.
